// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue sequencer for the ALU micro-register interface
// Fixed 4-cycle IDLE->EX1->EX2->WB op sequence with an internal register file and writeback.
`ifndef CPU_STATES
`define CPU_STATES 4
`endif
`ifndef EXECUTE1
`define EXECUTE1 1
`endif
`ifndef EXECUTE2
`define EXECUTE2 2
`endif

module alu_op_sequencer #(
  parameter int ALU_WIDTH = 8,
  parameter int NUM_REGS  = 8,
  parameter int IDLE_CODE = 0,
  localparam int RA  = $clog2(NUM_REGS),
  localparam int CSW = $clog2(`CPU_STATES)
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [RA-1:0]        req_rs1,
  input  logic [RA-1:0]        req_rs2,
  input  logic [RA-1:0]        req_rd,
  input  logic                 ld_en,
  input  logic [RA-1:0]        ld_addr,
  input  logic [ALU_WIDTH-1:0] ld_data,
  input  logic [RA-1:0]        dbg_raddr,
  output logic [ALU_WIDTH-1:0] dbg_rdata,
  output logic [CSW-1:0]       cpu_state,
  output logic [ALU_WIDTH-1:0] A_bus,
  output logic [ALU_WIDTH-1:0] B_bus,
  output logic                 alu_en_A_reg,
  output logic                 alu_en_B_reg,
  output logic [3:0]           alu_op,
  input  logic [ALU_WIDTH-1:0] alu_result,
  input  logic                 cc_greater,
  input  logic                 cc_equal,
  output logic                 done_valid,
  output logic [RA-1:0]        done_rd,
  output logic [ALU_WIDTH-1:0] done_data,
  output logic                 flag_greater,
  output logic                 flag_equal,
  output logic                 illegal_op
);

  localparam logic [CSW-1:0] L_IDLE = CSW'(IDLE_CODE);
  localparam logic [CSW-1:0] L_EX1  = CSW'(`EXECUTE1);
  localparam logic [CSW-1:0] L_EX2  = CSW'(`EXECUTE2);

  typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_WB} state_t;

  state_t               r_state;
  logic [3:0]           r_op;
  logic [RA-1:0]        r_rd;
  logic [ALU_WIDTH-1:0] r_rf [NUM_REGS];

  logic                 w_accept;
  logic                 w_wb_write;
  logic [ALU_WIDTH-1:0] w_wb_data;
  logic [ALU_WIDTH-1:0] w_opa;
  logic [ALU_WIDTH-1:0] w_opb;

  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid && req_ready;
  // A load landing in the accept cycle is forwarded so the op sees the new value
  assign w_opa      = (ld_en && (ld_addr == req_rs1)) ? ld_data : r_rf[req_rs1];
  assign w_opb      = (ld_en && (ld_addr == req_rs2)) ? ld_data : r_rf[req_rs2];
  assign w_wb_write = (r_state == S_WB) && (r_op <= 4'd8);
  assign w_wb_data  = (r_op == 4'd0) ? '0 : alu_result;
  assign dbg_rdata  = r_rf[dbg_raddr];
  assign done_rd    = r_rd;
  assign done_data  = (r_state == S_WB) ? alu_result : '0;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_rd         <= '0;
      cpu_state    <= L_IDLE;
      A_bus        <= '0;
      B_bus        <= '0;
      alu_op       <= '0;
      alu_en_A_reg <= 1'b0;
      alu_en_B_reg <= 1'b0;
      done_valid   <= 1'b0;
      illegal_op   <= 1'b0;
      flag_greater <= 1'b0;
      flag_equal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_EX1;
            r_op         <= req_op;
            r_rd         <= req_rd;
            A_bus        <= w_opa;
            B_bus        <= w_opb;
            alu_op       <= req_op;
            alu_en_A_reg <= 1'b1;
            alu_en_B_reg <= 1'b1;
            cpu_state    <= L_EX1;
          end
        end
        S_EX1: begin
          r_state   <= S_EX2;
          cpu_state <= L_EX2;
        end
        S_EX2: begin
          r_state      <= S_WB;
          cpu_state    <= L_IDLE;
          alu_en_A_reg <= 1'b0;
          alu_en_B_reg <= 1'b0;
          done_valid   <= 1'b1;
          illegal_op   <= (r_op >= 4'd10);
        end
        S_WB: begin
          r_state    <= S_IDLE;
          done_valid <= 1'b0;
          illegal_op <= 1'b0;
          A_bus      <= '0;
          B_bus      <= '0;
          alu_op     <= '0;
          if (r_op == 4'd9) begin
            flag_greater <= cc_greater;
            flag_equal   <= cc_equal;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback is assigned last so it overrides an external load to the same entry
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else begin
      if (ld_en) r_rf[ld_addr] <= ld_data;
      if (w_wb_write) r_rf[r_rd] <= w_wb_data;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
// Includes a registered ALU stand-in that loads on EX1->EX2 and produces results on EX2->WB.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0;
  logic [2:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [2:0] dbg_raddr = '0;
  logic [7:0] dbg_rdata;
  logic [1:0] cpu_state;
  logic [7:0] A_bus, B_bus;
  logic       alu_en_A_reg, alu_en_B_reg;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       cc_greater, cc_equal;
  logic       done_valid;
  logic [2:0] done_rd;
  logic [7:0] done_data;
  logic       flag_greater, flag_equal, illegal_op;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    logic       ill;
    int         due;
  } exp_t;
  exp_t q[$];

  alu_op_sequencer dut (
    .sys_clk(clk), .sys_reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .cpu_state(cpu_state), .A_bus(A_bus), .B_bus(B_bus),
    .alu_en_A_reg(alu_en_A_reg), .alu_en_B_reg(alu_en_B_reg), .alu_op(alu_op),
    .alu_result(alu_result), .cc_greater(cc_greater), .cc_equal(cc_equal),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .flag_greater(flag_greater), .flag_equal(flag_equal), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_a, m_b;
  logic [3:0] m_op;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_op <= '0;
      alu_result <= '0; cc_greater <= 1'b0; cc_equal <= 1'b0;
    end else begin
      if (cpu_state == 2'd1 && alu_en_A_reg && alu_en_B_reg) begin
        m_a <= A_bus; m_b <= B_bus; m_op <= alu_op;
      end
      if (cpu_state == 2'd2) begin
        case (m_op)
          4'd0: alu_result <= 8'h00;
          4'd1: alu_result <= m_a + m_b;
          4'd2: alu_result <= m_a - m_b;
          4'd3: alu_result <= m_a | m_b;
          4'd4: alu_result <= m_a & m_b;
          4'd5: alu_result <= ~m_a;
          4'd6: alu_result <= m_a << m_b[2:0];
          4'd7: alu_result <= m_a >> m_b[2:0];
          4'd8: alu_result <= $unsigned($signed(m_a) >>> m_b[2:0]);
          4'd9: alu_result <= m_a - m_b;
          default: alu_result <= 8'hA5;
        endcase
        cc_greater <= (m_a > m_b);
        cc_equal   <= (m_a == m_b);
      end
    end
  end

  always @(negedge clk) begin
    if (done_valid) begin
      if (q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_done: rd=%0d data=0x%0h with no op pending", done_rd, done_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_vec++;
        if (done_rd !== e.rd || done_data !== e.data || illegal_op !== e.ill || cyc != e.due) begin
          n_miss++;
          $display("FAIL done: got rd=%0d data=0x%0h ill=%0b cyc=%0d, expected rd=%0d data=0x%0h ill=%0b cyc=%0d",
                   done_rd, done_data, illegal_op, cyc, e.rd, e.data, e.ill, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rf_chk(input logic [2:0] addr, input logic [7:0] exp);
    dbg_raddr = addr;
    #1;
    check($sformatf("rf[%0d]", addr), {24'h0, dbg_rdata}, {24'h0, exp});
  endtask

  task automatic ld(input logic [2:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic [7:0] exp_data, input logic exp_ill,
                       input logic bp_en, input logic [2:0] bp_addr, input logic [7:0] bp_data,
                       input logic wb_en, input logic [2:0] wb_addr, input logic [7:0] wb_data);
    check("req_ready_before", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    ld_en = bp_en; ld_addr = bp_addr; ld_data = bp_data;
    @(posedge clk); #1;
    req_valid = 1'b0; ld_en = 1'b0;
    q.push_back('{rd: rd, data: exp_data, ill: exp_ill, due: cyc + 2});
    check("ex1_state", {30'h0, cpu_state, alu_en_A_reg, alu_en_B_reg}, {30'h0, 2'd1, 2'b11});
    @(posedge clk); #1;
    check("ex2_state", {30'h0, cpu_state, alu_en_A_reg, alu_en_B_reg}, {30'h0, 2'd2, 2'b11});
    @(posedge clk); #1;
    ld_en = wb_en; ld_addr = wb_addr; ld_data = wb_data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_state", {30'h0, cpu_state}, 32'h0);
    check("rst_buses", {16'h0, A_bus, B_bus}, 32'h0);
    check("rst_flags", {30'h0, flag_greater, flag_equal}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic add
    ld(3'd1, 8'h05); ld(3'd2, 8'h03);
    issue(4'd1, 3'd1, 3'd2, 3'd3, 8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    rf_chk(3'd3, 8'h08);

    // 2: sub with wrap
    ld(3'd1, 8'h02); ld(3'd2, 8'h05);
    issue(4'd2, 3'd1, 3'd2, 3'd4, 8'hFD, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    rf_chk(3'd4, 8'hFD);
    check("flags_after_sub", {30'h0, flag_greater, flag_equal}, 32'h0);

    // 3: cmp equal, non-cmp op leaves flags, cmp greater
    ld(3'd1, 8'h7A); ld(3'd2, 8'h7A);
    issue(4'd9, 3'd1, 3'd2, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    check("flags_cmp_eq", {30'h0, flag_greater, flag_equal}, 32'h1);
    rf_chk(3'd5, 8'h00);
    issue(4'd2, 3'd4, 3'd1, 3'd6, 8'h83, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    check("flags_held_sub", {30'h0, flag_greater, flag_equal}, 32'h1);
    rf_chk(3'd6, 8'h83);
    ld(3'd1, 8'h80);
    issue(4'd9, 3'd1, 3'd2, 3'd5, 8'h06, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    check("flags_cmp_gt", {30'h0, flag_greater, flag_equal}, 32'h2);
    rf_chk(3'd5, 8'h00);

    // 4: load bypass on accept
    ld(3'd2, 8'h01);
    issue(4'd1, 3'd1, 3'd2, 3'd7, 8'h12, 1'b0, 1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 8'h00);
    rf_chk(3'd7, 8'h12);
    rf_chk(3'd1, 8'h11);

    // 6: illegal op, WB-vs-ld collision, ld alongside WB, nop
    issue(4'd12, 3'd1, 3'd2, 3'd3, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    rf_chk(3'd3, 8'h08);
    check("flags_after_illegal", {30'h0, flag_greater, flag_equal}, 32'h2);
    issue(4'd1, 3'd1, 3'd2, 3'd6, 8'h12, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h55);
    rf_chk(3'd6, 8'h12);
    issue(4'd1, 3'd1, 3'd2, 3'd3, 8'h12, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h33);
    rf_chk(3'd3, 8'h12);
    rf_chk(3'd0, 8'h33);
    issue(4'd0, 3'd1, 3'd2, 3'd4, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    rf_chk(3'd4, 8'h00);

    // 5: reset during EX2 discards the op
    req_valid = 1'b1; req_op = 4'd1; req_rs1 = 3'd1; req_rs2 = 3'd2; req_rd = 3'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_ex2", {30'h0, cpu_state}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {14'h0, cpu_state, alu_en_A_reg, alu_en_B_reg, A_bus, B_bus}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_ready", {31'h0, req_ready}, 32'h1);
    check("post_reset_flags", {30'h0, flag_greater, flag_equal}, 32'h0);
    for (int i = 0; i < 8; i++) rf_chk(3'(i), 8'h00);

    check("scoreboard_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
